// File: rtl/rv_trap_ctrl.sv
// rv_trap_ctrl: machine-mode trap sequencer.
// Accepts one exception, MRET or enabled interrupt while idle, flushes the
// pipeline, commits mepc/mcause/mtval and the mstatus MIE/MPIE bits, and then
// issues a single redirect to fetch. This block holds mstatus.MIE and MPIE.
// Optional feature macro: RV_TRAP_VECTORED_EN (vectored interrupt targets).
// When it is undefined, only direct mode exists and no offset adder is built.

module rv_trap_ctrl #(
   parameter int EXTENSION_C = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_exc_valid,
   input  logic [3:0]  i_exc_code,
   input  logic [31:1] i_exc_pc,
   input  logic [31:0] i_exc_tval,
   input  logic        i_mret,
   input  logic [2:0]  i_irq_pending,
   input  logic [2:0]  i_irq_enable,
   input  logic        i_boundary,
   input  logic [31:1] i_next_pc,
   input  logic [31:0] i_mtvec,
   input  logic [31:1] i_mepc,
   input  logic        i_mstatus_we,
   input  logic [31:0] i_mstatus_wdata,
   input  logic        i_pipe_empty,
   input  logic        i_fetch_ready,
   output logic        o_busy,
   output logic        o_flush,
   output logic        o_csr_wr,
   output logic [31:1] o_mepc,
   output logic [31:0] o_mcause,
   output logic [31:0] o_mtval,
   output logic        o_mie,
   output logic        o_mpie,
   output logic        o_redirect,
   output logic [31:1] o_redirect_pc
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DRAIN    = 2'd1;
   localparam logic [1:0] COMMIT   = 2'd2;
   localparam logic [1:0] REDIRECT = 2'd3;

   logic [1:0]  state;
   logic        mie;
   logic        mpie;
   logic        kind_ret;     // latched sequence kind: 1 = MRET, 0 = trap
   logic [31:1] trap_epc;
   logic [31:0] trap_cause;
   logic [31:0] trap_tval;
   logic [31:1] target_pc;

   logic [2:0]  irq_eligible;
   logic        accept;
   logic        accept_ret;
   logic [31:0] new_cause;
   logic [31:1] new_epc;
   logic [31:0] new_tval;
   logic [31:0] trap_addr;
   logic [31:1] next_target;
   logic        unused_bits;

   // Source arbitration: exception > MRET > external > soft > timer interrupt.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      irq_eligible = i_irq_pending & i_irq_enable & {3{mie & i_boundary}};
      accept       = 1'b0;
      accept_ret   = 1'b0;
      new_cause    = '0;
      new_epc      = '0;
      new_tval     = '0;
      if (i_exc_valid) begin
         accept    = 1'b1;
         new_cause = {28'd0, i_exc_code};
         new_epc   = i_exc_pc;
         new_tval  = i_exc_tval;
      end else if (i_mret) begin
         accept     = 1'b1;
         accept_ret = 1'b1;
      end else if (irq_eligible[2]) begin
         accept    = 1'b1;
         new_cause = 32'h8000_000B;
         new_epc   = i_next_pc;
      end else if (irq_eligible[0]) begin
         accept    = 1'b1;
         new_cause = 32'h8000_0003;
         new_epc   = i_next_pc;
      end else if (irq_eligible[1]) begin
         accept    = 1'b1;
         new_cause = 32'h8000_0007;
         new_epc   = i_next_pc;
      end
   end

   // Redirect target, evaluated during COMMIT from the live mtvec/mepc inputs.
   always_comb begin
      trap_addr = {i_mtvec[31:2], 2'b00};
`ifdef RV_TRAP_VECTORED_EN
      // Only interrupts vector; the offset wraps modulo 2^32.
      if (trap_cause[31] && (i_mtvec[1:0] == 2'b01))
         trap_addr = {i_mtvec[31:2], 2'b00} + {26'd0, trap_cause[3:0], 2'b00};
`endif
      next_target = kind_ret ? i_mepc : trap_addr[31:1];
      // Without compressed support every target is word aligned.
      if (EXTENSION_C == 0)
         next_target[1] = 1'b0;
   end

   // Sequencer state, latched trap record and the mstatus MIE/MPIE bits.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (i_reset) begin
         state      <= IDLE;
         mie        <= 1'b0;
         mpie       <= 1'b0;
         kind_ret   <= 1'b0;
         trap_epc   <= '0;
         trap_cause <= '0;
         trap_tval  <= '0;
         target_pc  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Eligibility above already used the pre-write MIE.
               if (i_mstatus_we) begin
                  mie  <= i_mstatus_wdata[3];
                  mpie <= i_mstatus_wdata[7];
               end
               if (accept) begin
                  state    <= DRAIN;
                  kind_ret <= accept_ret;
                  if (!accept_ret) begin
                     trap_epc   <= new_epc;
                     trap_cause <= new_cause;
                     trap_tval  <= new_tval;
                  end
               end
            end
            DRAIN: begin
               if (i_pipe_empty)
                  state <= COMMIT;
            end
            COMMIT: begin
               target_pc <= next_target;
               if (kind_ret) begin
                  mie  <= mpie;
                  mpie <= 1'b1;
               end else begin
                  mpie <= mie;
                  mie  <= 1'b0;
               end
               state <= REDIRECT;
            end
            default: begin
               if (i_fetch_ready)
                  state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy        = (state != IDLE);
   assign o_flush       = (state == DRAIN);
   assign o_csr_wr      = (state == COMMIT) && !kind_ret;
   assign o_mepc        = trap_epc;
   assign o_mcause      = trap_cause;
   assign o_mtval       = trap_tval;
   assign o_mie         = mie;
   assign o_mpie        = mpie;
   assign o_redirect    = (state == REDIRECT);
   assign o_redirect_pc = target_pc;

   // Input bits this block deliberately does not look at.
   assign unused_bits = ^{i_mstatus_wdata[31:8], i_mstatus_wdata[6:4],
                          i_mstatus_wdata[2:0], i_mtvec[1:0], trap_addr[0]};

endmodule

// File: tb/tb_rv_trap_ctrl.sv
// Self-checking bench for rv_trap_ctrl: directed vector table, hand-written
// stall/reset/mstatus sequences, then randomized transactions against a
// rule-level reference model. A second instance with EXTENSION_C = 0 shares
// all inputs and is checked for word-aligned redirect targets.

module tb_rv_trap_ctrl;

   typedef struct {
      logic        exc_valid;
      logic [3:0]  code;
      logic [31:1] pc;
      logic [31:0] tval;
      logic        mret;
      logic [2:0]  pend;
      logic [2:0]  en;
      logic        boundary;
      logic [31:1] next_pc;
      logic [31:0] mtvec;
      logic [31:1] mepc;
      logic        mie0;
      logic        mpie0;
   } stim_t;

   typedef struct {
      logic        taken;
      logic        csr_wr;
      logic [31:1] mepc;
      logic [31:0] mcause;
      logic [31:0] mtval;
      logic [31:1] target;
      logic        mie;
      logic        mpie;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

`ifdef RV_TRAP_VECTORED_EN
   localparam bit          VECTORED = 1'b1;
   localparam logic [31:1] VEC_T    = 31'h400E;  // 0x801C
   localparam logic [31:1] VEC_S    = 31'h4006;  // 0x800C
`else
   localparam bit          VECTORED = 1'b0;
   localparam logic [31:1] VEC_T    = 31'h4000;  // 0x8000
   localparam logic [31:1] VEC_S    = 31'h4000;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        exc_valid;
   logic [3:0]  exc_code;
   logic [31:1] exc_pc;
   logic [31:0] exc_tval;
   logic        mret;
   logic [2:0]  irq_pending;
   logic [2:0]  irq_enable;
   logic        boundary;
   logic [31:1] next_pc;
   logic [31:0] mtvec;
   logic [31:1] mepc_in;
   logic        mstatus_we;
   logic [31:0] mstatus_wdata;
   logic        pipe_empty;
   logic        fetch_ready;

   logic        busy, flush, csr_wr, mie, mpie, redirect;
   logic [31:1] mepc_out, redirect_pc;
   logic [31:0] mcause, mtval;

   logic        nc_busy, nc_flush, nc_csr_wr, nc_mie, nc_mpie, nc_redirect;
   logic [31:1] nc_mepc, nc_redirect_pc;
   logic [31:0] nc_mcause, nc_mtval;

   int checks = 0;
   int errors = 0;
   bit model_mie  = 1'b0;
   bit model_mpie = 1'b0;

   always #5 clk = ~clk;

   rv_trap_ctrl #(.EXTENSION_C(1)) dut (
      .i_clk(clk), .i_reset(reset), .i_exc_valid(exc_valid), .i_exc_code(exc_code),
      .i_exc_pc(exc_pc), .i_exc_tval(exc_tval), .i_mret(mret),
      .i_irq_pending(irq_pending), .i_irq_enable(irq_enable), .i_boundary(boundary),
      .i_next_pc(next_pc), .i_mtvec(mtvec), .i_mepc(mepc_in),
      .i_mstatus_we(mstatus_we), .i_mstatus_wdata(mstatus_wdata),
      .i_pipe_empty(pipe_empty), .i_fetch_ready(fetch_ready),
      .o_busy(busy), .o_flush(flush), .o_csr_wr(csr_wr), .o_mepc(mepc_out),
      .o_mcause(mcause), .o_mtval(mtval), .o_mie(mie), .o_mpie(mpie),
      .o_redirect(redirect), .o_redirect_pc(redirect_pc)
   );

   rv_trap_ctrl #(.EXTENSION_C(0)) dut_nc (
      .i_clk(clk), .i_reset(reset), .i_exc_valid(exc_valid), .i_exc_code(exc_code),
      .i_exc_pc(exc_pc), .i_exc_tval(exc_tval), .i_mret(mret),
      .i_irq_pending(irq_pending), .i_irq_enable(irq_enable), .i_boundary(boundary),
      .i_next_pc(next_pc), .i_mtvec(mtvec), .i_mepc(mepc_in),
      .i_mstatus_we(mstatus_we), .i_mstatus_wdata(mstatus_wdata),
      .i_pipe_empty(pipe_empty), .i_fetch_ready(fetch_ready),
      .o_busy(nc_busy), .o_flush(nc_flush), .o_csr_wr(nc_csr_wr), .o_mepc(nc_mepc),
      .o_mcause(nc_mcause), .o_mtval(nc_mtval), .o_mie(nc_mie), .o_mpie(nc_mpie),
      .o_redirect(nc_redirect), .o_redirect_pc(nc_redirect_pc)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sources();
      exc_valid   = 1'b0;
      exc_code    = '0;
      exc_pc      = '0;
      exc_tval    = '0;
      mret        = 1'b0;
      irq_pending = '0;
      irq_enable  = '0;
      boundary    = 1'b0;
      next_pc     = '0;
      mstatus_we  = 1'b0;
   endtask

   // Reference model: the outcome of one accepted source, straight from the
   // priority, cause-encoding and target rules.
   function automatic exp_t predict(input stim_t s);
      exp_t        e;
      logic [31:0] base;
      logic [31:0] addr;
      logic [2:0]  elig;
      int unsigned code;
      e = '{default: '0};
      base = {s.mtvec[31:2], 2'b00};
      addr = base;
      code = 0;
      elig = (s.mie0 && s.boundary) ? (s.pend & s.en) : 3'b000;
      if (s.exc_valid) begin
         e.taken  = 1'b1;
         e.csr_wr = 1'b1;
         e.mepc   = s.pc;
         e.mcause = {28'd0, s.code};
         e.mtval  = s.tval;
      end else if (!s.mret) begin
         if (elig[2])      code = 11;
         else if (elig[0]) code = 3;
         else if (elig[1]) code = 7;
         if (code != 0) begin
            e.taken  = 1'b1;
            e.csr_wr = 1'b1;
            e.mepc   = s.next_pc;
            e.mcause = 32'h8000_0000 | code;
            e.mtval  = 32'h0;
            if (VECTORED && s.mtvec[1:0] == 2'b01)
               addr = base + code * 4;
         end
      end else begin
         e.taken = 1'b1;
      end
      e.target = (s.mret && !s.exc_valid) ? s.mepc : addr[31:1];
      if (!e.taken) begin
         e.mie  = s.mie0;
         e.mpie = s.mpie0;
      end else if (!e.csr_wr) begin
         e.mie  = s.mpie0;
         e.mpie = 1'b1;
      end else begin
         e.mie  = 1'b0;
         e.mpie = s.mie0;
      end
      return e;
   endfunction

   // One full transaction: optional mstatus setup, acceptance, stalled DRAIN,
   // COMMIT, stalled REDIRECT and return to IDLE. Entered and left in IDLE.
   task automatic run_seq(input string tag, input stim_t s, input exp_t e,
                          input int drain_wait, input int fetch_wait, input bit do_write);
      if (do_write) begin
         clear_sources();
         mstatus_we    = 1'b1;
         mstatus_wdata = $urandom & 32'hFFFF_FF77;
         mstatus_wdata[3] = s.mie0;
         mstatus_wdata[7] = s.mpie0;
         tick();
         mstatus_we = 1'b0;
         check({tag, ".wr_mie"}, 32'(mie), 32'(s.mie0));
         check({tag, ".wr_mpie"}, 32'(mpie), 32'(s.mpie0));
      end
      exc_valid   = s.exc_valid;
      exc_code    = s.code;
      exc_pc      = s.pc;
      exc_tval    = s.tval;
      mret        = s.mret;
      irq_pending = s.pend;
      irq_enable  = s.en;
      boundary    = s.boundary;
      next_pc     = s.next_pc;
      mtvec       = s.mtvec;
      mepc_in     = s.mepc;
      pipe_empty  = (drain_wait == 0);
      fetch_ready = (fetch_wait == 0);
      tick();
      clear_sources();
      if (!e.taken) begin
         check({tag, ".idle_busy"}, 32'(busy), 32'd0);
         check({tag, ".idle_mie"}, 32'(mie), 32'(e.mie));
         return;
      end
      check({tag, ".drain_busy"}, 32'(busy), 32'd1);
      check({tag, ".drain_flush"}, 32'(flush), 32'd1);
      for (int i = 0; i < drain_wait; i++) begin
         tick();
         check({tag, ".drain_hold"}, 32'({flush, csr_wr}), 32'b10);
      end
      pipe_empty = 1'b1;
      tick();
      check({tag, ".commit_flush"}, 32'(flush), 32'd0);
      check({tag, ".commit_wr"}, 32'(csr_wr), 32'(e.csr_wr));
      if (e.csr_wr) begin
         check({tag, ".mepc"}, 32'(mepc_out), 32'(e.mepc));
         check({tag, ".mcause"}, mcause, e.mcause);
         check({tag, ".mtval"}, mtval, e.mtval);
      end
      tick();
      check({tag, ".redirect"}, 32'({busy, redirect, csr_wr}), 32'b110);
      check({tag, ".target"}, 32'(redirect_pc), 32'(e.target));
      check({tag, ".target_nc"}, 32'(nc_redirect_pc), 32'(e.target & 31'h7FFF_FFFE));
      check({tag, ".mie"}, 32'(mie), 32'(e.mie));
      check({tag, ".mpie"}, 32'(mpie), 32'(e.mpie));
      for (int i = 0; i < fetch_wait; i++) begin
         tick();
         check({tag, ".redir_hold"}, 32'(redirect), 32'd1);
         check({tag, ".redir_stable"}, 32'(redirect_pc), 32'(e.target));
      end
      fetch_ready = 1'b1;
      tick();
      check({tag, ".back_idle"}, 32'({busy, redirect}), 32'b00);
   endtask

   vec_t tbl[11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // fields: exc code pc tval | mret pend en bnd next_pc | mtvec mepc | mie0 mpie0
      // expect: taken csr_wr mepc mcause mtval target mie mpie
      tbl[0]  = '{'{1, 4'd3, 31'h80, 32'h0, 0, 3'b000, 3'b000, 0, 31'h0, 32'h8000, 31'h0, 1, 0},
                  '{1, 1, 31'h80, 32'h3, 32'h0, 31'h4000, 0, 1}};
      tbl[1]  = '{'{0, 4'd0, 31'h0, 32'h0, 0, 3'b110, 3'b111, 1, 31'h100, 32'h8000, 31'h0, 1, 0},
                  '{1, 1, 31'h100, 32'h8000_000B, 32'h0, 31'h4000, 0, 1}};
      tbl[2]  = '{'{0, 4'd0, 31'h0, 32'h0, 0, 3'b010, 3'b010, 1, 31'h100, 32'h8001, 31'h0, 1, 1},
                  '{1, 1, 31'h100, 32'h8000_0007, 32'h0, VEC_T, 0, 1}};
      tbl[3]  = '{'{0, 4'd0, 31'h0, 32'h0, 1, 3'b000, 3'b000, 0, 31'h0, 32'h8000, 31'h180, 0, 1},
                  '{1, 0, 31'h0, 32'h0, 32'h0, 31'h180, 1, 1}};
      tbl[4]  = '{'{1, 4'd2, 31'h91A, 32'hDEAD_BEEF, 0, 3'b000, 3'b000, 0, 31'h0, 32'h1_0000, 31'h0, 0, 1},
                  '{1, 1, 31'h91A, 32'h2, 32'hDEAD_BEEF, 31'h8000, 0, 0}};
      tbl[5]  = '{'{1, 4'd11, 31'h20, 32'h55, 1, 3'b111, 3'b111, 1, 31'h400, 32'h8001, 31'h300, 1, 0},
                  '{1, 1, 31'h20, 32'hB, 32'h55, 31'h4000, 0, 1}};
      tbl[6]  = '{'{0, 4'd0, 31'h0, 32'h0, 0, 3'b011, 3'b011, 1, 31'h1234, 32'h8001, 31'h0, 1, 0},
                  '{1, 1, 31'h1234, 32'h8000_0003, 32'h0, VEC_S, 0, 1}};
      tbl[7]  = '{'{0, 4'd0, 31'h0, 32'h0, 1, 3'b111, 3'b111, 1, 31'h50, 32'h8000, 31'h181, 1, 0},
                  '{1, 0, 31'h0, 32'h0, 32'h0, 31'h181, 0, 1}};
      tbl[8]  = '{'{0, 4'd0, 31'h0, 32'h0, 0, 3'b111, 3'b111, 0, 31'h50, 32'h8000, 31'h0, 1, 0},
                  '{0, 0, 31'h0, 32'h0, 32'h0, 31'h0, 1, 0}};
      tbl[9]  = '{'{0, 4'd0, 31'h0, 32'h0, 0, 3'b100, 3'b011, 1, 31'h50, 32'h8000, 31'h0, 1, 0},
                  '{0, 0, 31'h0, 32'h0, 32'h0, 31'h0, 1, 0}};
      tbl[10] = '{'{0, 4'd0, 31'h0, 32'h0, 0, 3'b111, 3'b111, 1, 31'h50, 32'h8000, 31'h0, 0, 1},
                  '{0, 0, 31'h0, 32'h0, 32'h0, 31'h0, 0, 1}};

      clear_sources();
      mtvec         = '0;
      mepc_in       = '0;
      mstatus_wdata = '0;
      pipe_empty    = 1'b1;
      fetch_ready   = 1'b1;
      reset         = 1'b1;
      repeat (3) tick();
      check("reset.ctrl", 32'({busy, flush, csr_wr, redirect}), 32'h0);
      check("reset.status", 32'({mie, mpie}), 32'h0);
      check("reset.mepc", 32'(mepc_out), 32'h0);
      check("reset.mcause", mcause, 32'h0);
      check("reset.mtval", mtval, 32'h0);
      check("reset.target", 32'(redirect_pc), 32'h0);
      reset = 1'b0;
      tick();

      // Directed table: no stalls, fresh mstatus for each vector.
      for (int i = 0; i < 11; i++)
         run_seq($sformatf("vec%0d", i), tbl[i].s, tbl[i].e, 0, 0, 1'b1);
      model_mie  = tbl[10].e.mie;
      model_mpie = tbl[10].e.mpie;

      // Stalls: pipeline busy for 4 DRAIN cycles (5 flush cycles total), fetch
      // busy for 3 REDIRECT cycles.
      begin
         stim_t s;
         s = '{1, 4'd11, 31'h600, 32'h77, 0, 3'b000, 3'b000, 0, 31'h0, 32'h2000, 31'h0, 1, 1};
         run_seq("stall", s, predict(s), 4, 3, 1'b1);
      end

      // Reset during DRAIN aborts the sequence.
      clear_sources();
      mstatus_we = 1'b1;
      mstatus_wdata = 32'h88;
      tick();
      mstatus_we = 1'b0;
      exc_valid  = 1'b1;
      exc_code   = 4'd3;
      exc_pc     = 31'h700;
      mtvec      = 32'h4000;
      pipe_empty = 1'b0;
      tick();
      clear_sources();
      check("rst_mid.drain", 32'(flush), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      pipe_empty  = 1'b1;
      fetch_ready = 1'b1;
      check("rst_mid.status", 32'({busy, mie, mpie}), 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_mid.quiet", 32'({busy, csr_wr, redirect}), 32'h0);
      end
      model_mie  = 1'b0;
      model_mpie = 1'b0;

      // mstatus write of 0x8 races an eligible timer interrupt: the pre-write
      // MIE (0) governs that cycle, the interrupt is taken one cycle later.
      mstatus_we    = 1'b1;
      mstatus_wdata = 32'h8;
      irq_pending   = 3'b010;
      irq_enable    = 3'b111;
      boundary      = 1'b1;
      next_pc       = 31'h900;
      mtvec         = 32'h8000;
      tick();
      mstatus_we = 1'b0;
      check("mswr.not_taken", 32'(busy), 32'd0);
      check("mswr.mie", 32'(mie), 32'd1);
      tick();
      clear_sources();
      check("mswr.taken", 32'(busy), 32'd1);
      tick();
      check("mswr.commit", 32'(csr_wr), 32'd1);
      check("mswr.mcause", mcause, 32'h8000_0007);
      check("mswr.mepc", 32'(mepc_out), 32'h900);
      tick();
      check("mswr.redirect", 32'(redirect), 32'd1);
      check("mswr.status", 32'({mie, mpie}), 32'b01);
      tick();
      check("mswr.idle", 32'(busy), 32'd0);
      model_mie  = 1'b0;
      model_mpie = 1'b1;

      // Randomized transactions; without a write the source arrives in the
      // first IDLE cycle after the previous REDIRECT.
      for (int n = 0; n < 60; n++) begin
         stim_t s;
         exp_t  e;
         bit    wr;
         int    kind;
         kind = $urandom_range(0, 3);
         s.exc_valid = (kind == 0);
         s.code      = 4'($urandom_range(0, 15));
         s.pc        = 31'($urandom);
         s.tval      = $urandom;
         s.mret      = (kind == 1) || ($urandom_range(0, 5) == 0);
         s.pend      = 3'($urandom);
         s.en        = 3'($urandom);
         s.boundary  = ($urandom_range(0, 4) != 0);
         s.next_pc   = 31'($urandom);
         s.mtvec     = $urandom;
         if ($urandom_range(0, 1) == 1) s.mtvec[1:0] = 2'b01;
         if ($urandom_range(0, 7) == 0) s.mtvec = 32'hFFFF_FFF1;
         s.mepc      = 31'($urandom);
         wr = ($urandom_range(0, 1) == 1);
         if (wr) begin
            model_mie  = 1'($urandom);
            model_mpie = 1'($urandom);
         end
         s.mie0  = model_mie;
         s.mpie0 = model_mpie;
         e = predict(s);
         run_seq($sformatf("rnd%0d", n), s, e, $urandom_range(0, 3), $urandom_range(0, 3), wr);
         model_mie  = e.mie;
         model_mpie = e.mpie;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_trap_ctrl.md
# rv_trap_ctrl

Machine-mode trap sequencer sitting between the pipeline and the machine CSR file. It picks the highest-priority synchronous exception or enabled pending interrupt, or an MRET, and drains the pipeline. It then commits mepc/mcause/mtval and the mstatus MIE/MPIE bits, and issues a single redirect to fetch. It owns mstatus.MIE and mstatus.MPIE; the CSR file reads them from here.

## Interface
Parameters:
- EXTENSION_C, 1, compressed support; when 0, bit 1 of every target PC is forced to 0.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_exc_valid  in  1  synchronous exception from the retiring instruction
- i_exc_code  in  4  exception cause (3 = ebreak, 11 = ecall-M, 2 = illegal)
- i_exc_pc  in  31  PC[31:1] of the faulting instruction
- i_exc_tval  in  32  trap value
- i_mret  in  1  MRET retiring
- i_irq_pending  in  3  {external, timer, soft} pending
- i_irq_enable  in  3  {MEIE, MTIE, MSIE} from mie
- i_boundary  in  1  instruction boundary; interrupts may be taken
- i_next_pc  in  31  PC[31:1] of the next instruction to execute
- i_mtvec  in  32  mtvec value
- i_mepc  in  31  current mepc, used for the MRET target
- i_mstatus_we  in  1  software write to mstatus (MIE = bit 3, MPIE = bit 7)
- i_mstatus_wdata  in  32  write data
- i_pipe_empty  in  1  pipeline drained
- i_fetch_ready  in  1  fetch accepts a redirect
- o_busy  out  1  controller not in IDLE; stall issue
- o_flush  out  1  kill in-flight instructions
- o_csr_wr  out  1  one-cycle commit strobe for mepc/mcause/mtval
- o_mepc  out  31  value to store into mepc
- o_mcause  out  32  {is_int, 27'b0, code[3:0]}
- o_mtval  out  32  value to store into mtval (0 for interrupts)
- o_mie  out  1  mstatus.MIE
- o_mpie  out  1  mstatus.MPIE
- o_redirect  out  1  redirect valid
- o_redirect_pc  out  31  redirect target PC[31:1]

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- Source priority when several are present in IDLE:
  - i_exc_valid (highest),
  - then i_mret,
  - then interrupts: external (code 11) > soft (3) > timer (7).
- An interrupt is eligible only when its pending bit, its enable bit, o_mie and i_boundary are all 1.
- IDLE -> DRAIN on any accepted source. On acceptance, latch:
  - kind: trap or return,
  - mcause,
  - epc: i_exc_pc for exceptions, i_next_pc for interrupts,
  - tval: i_exc_tval for exceptions, 0 for interrupts.
- DRAIN:
  - o_flush = 1.
  - Leave for COMMIT in the cycle after i_pipe_empty = 1 is sampled.
- COMMIT, trap kind:
  - o_csr_wr = 1 for one cycle, with o_mepc/o_mcause/o_mtval driven from the latched values.
  - MPIE <= MIE, MIE <= 0.
- COMMIT, return kind:
  - o_csr_wr = 0.
  - MIE <= MPIE, MPIE <= 1.
  - Target = i_mepc, sampled in this cycle.
- Trap target: {i_mtvec[31:2], 1'b0}; vectored variant described under Configuration.
- REDIRECT:
  - o_redirect = 1 and o_redirect_pc stable until i_fetch_ready = 1.
  - -> IDLE in the cycle after the handshake.
- Software mstatus write:
  - Applied only in IDLE.
  - Ignored in every other state.
  - Interrupt eligibility in the write cycle uses the pre-write MIE.
- Sources that arrive outside IDLE are ignored. The pipeline is stalled by o_busy, so none should arrive.

## Timing
- Reset:
  - State = IDLE, MIE = MPIE = 0.
  - o_busy, o_flush, o_csr_wr and o_redirect = 0.
  - Data outputs = 0.
- Reset asserted mid-sequence aborts it: no CSR write, no redirect.
- Minimum sequence, with i_pipe_empty and i_fetch_ready already 1:
  - acceptance at cycle N,
  - DRAIN at N+1,
  - COMMIT at N+2,
  - REDIRECT at N+3,
  - IDLE at N+4.
- o_busy is 1 from N+1 through the REDIRECT cycle.
- The controller can accept a new source in the IDLE cycle immediately after REDIRECT.
- Arithmetic: vector offset = code << 2, added modulo 2^32 to the base; wrap-around beyond 0xFFFF_FFFC is silently truncated.
- With EXTENSION_C = 0, o_redirect_pc[1] = 0.

## Configuration
- RV_TRAP_VECTORED_EN:
  - Defined: interrupts with i_mtvec[1:0] = 2'b01 jump to {i_mtvec[31:2], 2'b00} + 4*code. Exceptions always use the base.
  - Undefined: i_mtvec[1:0] is ignored and all traps use the base (direct mode only). No adder is synthesized.

## Test plan
- ebreak: i_exc_valid = 1, code 3, pc 0x100, mtvec 0x8000, MIE = 1 -> o_csr_wr pulse with mepc 0x100, mcause 3, then MIE = 0, MPIE = 1, redirect to 0x8000 at N+3.
- Timer + external both pending and enabled at a boundary, next_pc 0x200 -> mcause 0x8000000B, mepc 0x200, mtval 0; timer stays pending.
- Vectored mode, mtvec 0x8001, timer interrupt -> redirect to 0x801C with the macro defined, 0x8000 without it.
- MRET with MPIE = 1, MIE = 0, i_mepc 0x300 -> MIE = 1, MPIE = 1, no o_csr_wr, redirect to 0x300.
- i_pipe_empty held 0 for 5 cycles and i_fetch_ready 0 for 3 -> o_flush held 5 cycles, o_redirect held stable until the ack; reset asserted during DRAIN -> no o_csr_wr, no redirect, MIE = 0.
- Software mstatus write of 0x8 in IDLE with a pending enabled interrupt in the same cycle -> interrupt not taken that cycle, taken the next cycle.
